// File: rtl/bwram_pkg.sv
// Shared types for the byte-write RAM: write-mode selector, clear FSM states and index sizing.
package bwram_pkg;

    typedef enum logic [1:0] {
        READ_FIRST  = 2'd0,
        WRITE_FIRST = 2'd1,
        NO_CHANGE   = 2'd2
    } write_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Word-index width for a given depth, never below one bit.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bwram_clear_fsm.sv
// Clear sequencer: on a clr pulse walks every word address once, asserting a write strobe per cycle.
module bwram_clear_fsm
    import bwram_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned IW    = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          busy,
    output logic [IW-1:0] clr_addr,
    output logic          clr_we
);

    clr_state_e state;

    // busy tracks the CLEAR state exactly; clr is ignored while clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            clr_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr) begin
                        state    <= ST_CLEAR;
                        busy     <= 1'b1;
                        clr_addr <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_addr == IW'(DEPTH - 1)) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + IW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we = busy;

endmodule

// File: rtl/bytewrite_ram_mode.sv
// Single-port byte-write RAM with selectable write mode and a sequenced array clear.
// Define BWRAM_OUTREG_EN to add one output register stage (read latency 2).
module bytewrite_ram_mode
    import bwram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned NB_COL     = 4,
    parameter write_mode_e WRITE_MODE = READ_FIRST
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [NB_COL-1:0]             we,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic [NB_COL*COL_WIDTH-1:0]   di,
    input  logic                          clr,
    output logic                          busy,
    output logic [NB_COL*COL_WIDTH-1:0]   dout,
    output logic                          dout_valid
);

    localparam int unsigned W  = NB_COL * COL_WIDTH;
    localparam int unsigned IW = idx_width(DEPTH);

    logic          clr_we;
    logic [IW-1:0] clr_addr;

    bwram_clear_fsm #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    logic          accept_c;
    logic          in_range_c;
    logic [IW-1:0] idx_c;
    logic [W-1:0]  old_c;
    logic [W-1:0]  merged_c;

    // clr wins over a same-cycle access; the extra MSB keeps DEPTH == 2**ADDR_WIDTH representable.
    assign accept_c   = en & ~busy & ~clr;
    assign in_range_c = {1'b0, addr} < (ADDR_WIDTH + 1)'(DEPTH);
    assign idx_c      = addr[IW-1:0];

    for (genvar c = 0; c < int'(NB_COL); c++) begin : g_col
        logic [COL_WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end else if (accept_c && in_range_c && we[c]) begin
                mem[idx_c] <= di[c*COL_WIDTH +: COL_WIDTH];
            end
        end

        assign old_c[c*COL_WIDTH +: COL_WIDTH]    = in_range_c ? mem[idx_c] : '0;
        assign merged_c[c*COL_WIDTH +: COL_WIDTH] = !in_range_c ? '0 :
                                                    (we[c] ? di[c*COL_WIDTH +: COL_WIDTH] : mem[idx_c]);
    end

    logic         load_c;
    logic [W-1:0] load_data_c;

    // Mode decides what the read port captures and whether a write updates it at all.
    always_comb begin
        load_c      = accept_c;
        load_data_c = old_c;
        if (WRITE_MODE == WRITE_FIRST) begin
            load_data_c = merged_c;
        end else if (WRITE_MODE == NO_CHANGE) begin
            load_c = accept_c && (we == '0);
        end
    end

    logic [W-1:0] rd_q;
    logic         rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= load_c;
            if (load_c) begin
                rd_q <= load_data_c;
            end
        end
    end

`ifdef BWRAM_OUTREG_EN
    logic [W-1:0] out_q;
    logic         out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= rd_q;
            out_valid_q <= rd_valid_q;
        end
    end

    assign dout       = out_q;
    assign dout_valid = out_valid_q;
`else
    assign dout       = rd_q;
    assign dout_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_bytewrite_ram_mode.sv
// Randomized self-checking bench: three instances (one per write mode) share stimulus against a word-level model.
module tb_bytewrite_ram_mode;
    import bwram_pkg::*;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned W     = 32;
`ifdef BWRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          clr;
    logic [3:0]    we;
    logic [AW-1:0] addr;
    logic [W-1:0]  di;
    logic [2:0][W-1:0] dout_m;
    logic [2:0]        valid_m;
    logic [2:0]        busy_m;

    bytewrite_ram_mode #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .COL_WIDTH(8), .NB_COL(4), .WRITE_MODE(READ_FIRST)) u_rf (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .di(di), .clr(clr),
        .busy(busy_m[0]), .dout(dout_m[0]), .dout_valid(valid_m[0]));
    bytewrite_ram_mode #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .COL_WIDTH(8), .NB_COL(4), .WRITE_MODE(WRITE_FIRST)) u_wf (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .di(di), .clr(clr),
        .busy(busy_m[1]), .dout(dout_m[1]), .dout_valid(valid_m[1]));
    bytewrite_ram_mode #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .COL_WIDTH(8), .NB_COL(4), .WRITE_MODE(NO_CHANGE)) u_nc (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .di(di), .clr(clr),
        .busy(busy_m[2]), .dout(dout_m[2]), .dout_valid(valid_m[2]));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] model_mem [DEPTH];
    logic [W-1:0] exp_dout  [3];
    logic         exp_valid [3];
    string        mname     [3] = '{"read_first", "write_first", "no_change"};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
        for (int m = 0; m < 3; m++) exp_valid[m] = 1'b0;
    endtask

    // Word-level model: old word, column merge, out-of-range reads as zero.
    task automatic model_access(input logic [3:0] w, input logic [AW-1:0] a, input logic [W-1:0] d);
        logic [W-1:0] old_w;
        logic [W-1:0] new_w;
        int           ia;
        bit           ok;
        ia    = int'(a);
        ok    = (ia < int'(DEPTH));
        old_w = ok ? model_mem[ia] : '0;
        new_w = old_w;
        for (int c = 0; c < 4; c++) if (w[c]) new_w[c*8 +: 8] = d[c*8 +: 8];
        if (ok) model_mem[ia] = new_w;
        else new_w = '0;
        exp_dout[0] = old_w;  exp_valid[0] = 1'b1;
        exp_dout[1] = new_w;  exp_valid[1] = 1'b1;
        if (w == 4'h0) begin
            exp_dout[2] = old_w; exp_valid[2] = 1'b1;
        end else begin
            exp_valid[2] = 1'b0;
        end
    endtask

    task automatic drive_access(input logic [3:0] w, input logic [AW-1:0] a, input logic [W-1:0] d);
        model_access(w, a, d);
        en = 1'b1; we = w; addr = a; di = d;
        tick();
        en = 1'b0; we = '0;
        repeat (LAT - 1) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; we = '0; addr = '0; di = '0;
        for (int m = 0; m < 3; m++) begin exp_dout[m] = '0; exp_valid[m] = 1'b0; end
        #3;
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (dout_m[m] !== '0 || valid_m[m] !== 1'b0 || busy_m[m] !== 1'b0) begin
                errors++;
                $display("FAIL reset_%s: dout=%h valid=%b busy=%b, required 0/0/0", mname[m], dout_m[m], valid_m[m], busy_m[m]);
            end
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Clear sequence; noisy drives accesses/clr during busy, with_access asserts en alongside the clr pulse.
    task automatic test_clear(input bit noisy, input bit with_access);
        int cnt [3];
        int guard;
        for (int m = 0; m < 3; m++) cnt[m] = 0;
        guard = 0;
        clr = 1'b1;
        if (with_access) begin en = 1'b1; we = 4'hF; addr = AW'(3); di = $urandom; end
        tick();
        clr = 1'b0; en = 1'b0; we = '0;
        for (int m = 0; m < 3; m++) exp_valid[m] = 1'b0;
        while ((busy_m != 3'b000) && guard < 200) begin
            for (int m = 0; m < 3; m++) if (busy_m[m]) cnt[m]++;
            if (noisy) begin
                en = 1'(($urandom % 4) != 0); we = 4'($urandom); addr = AW'($urandom_range(0, 47));
                di = $urandom; clr = 1'(($urandom % 5) == 0);
            end
            tick();
            guard++;
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (valid_m[m] !== 1'b0 || dout_m[m] !== exp_dout[m]) begin
                    errors++;
                    $display("FAIL clear_hold_%s: dout=%h valid=%b, required %h/0", mname[m], dout_m[m], valid_m[m], exp_dout[m]);
                end
            end
        end
        en = 1'b0; clr = 1'b0; we = '0;
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (cnt[m] != int'(DEPTH)) begin
                errors++;
                $display("FAIL busy_len_%s: %0d cycles, required %0d", mname[m], cnt[m], DEPTH);
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
        for (int a = 0; a < int'(DEPTH); a++) begin
            drive_access(4'h0, AW'(a), $urandom);
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (dout_m[m] !== 32'h0 || valid_m[m] !== 1'b1) begin
                    errors++;
                    $display("FAIL clear_read_%s@%0d: dout=%h valid=%b, required 0/1", mname[m], a, dout_m[m], valid_m[m]);
                end
            end
            idle(1);
        end
    endtask

    task automatic test_rw_modes();
        logic [W-1:0] rd [4];
        drive_access(4'hF, AW'(5), 32'h11223344);
        idle(1);
        drive_access(4'b0011, AW'(5), 32'hAABBCCDD);
        rd[0] = dout_m[0]; rd[1] = dout_m[1];
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (dout_m[m] !== exp_dout[m] || valid_m[m] !== exp_valid[m]) begin
                errors++;
                $display("FAIL partial_write_%s: dout=%h valid=%b, required %h/%b", mname[m], dout_m[m], valid_m[m], exp_dout[m], exp_valid[m]);
            end
        end
        checks++;
        if (rd[0] !== 32'h11223344 || rd[1] !== 32'h1122CCDD) begin
            errors++;
            $display("FAIL mode_constants: rf=%h wf=%h, required 11223344/1122ccdd", rd[0], rd[1]);
        end
        idle(1);
        drive_access(4'h0, AW'(5), $urandom);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (dout_m[m] !== 32'h1122CCDD || valid_m[m] !== 1'b1) begin
                errors++;
                $display("FAIL readback_%s: dout=%h valid=%b, required 1122ccdd/1", mname[m], dout_m[m], valid_m[m]);
            end
        end
        idle(1);
        drive_access(4'b1000, AW'(5), 32'h5A000000);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (dout_m[m] !== exp_dout[m] || valid_m[m] !== exp_valid[m]) begin
                errors++;
                $display("FAIL nc_write_%s: dout=%h valid=%b, required %h/%b", mname[m], dout_m[m], valid_m[m], exp_dout[m], exp_valid[m]);
            end
        end
        idle(1);
    endtask

    task automatic test_out_of_range();
        drive_access(4'hF, AW'(8), 32'hCAFEF00D);
        idle(1);
        drive_access(4'h0, AW'(8), '0);
        idle(1);
        drive_access(4'hF, AW'(40), 32'h0BADBEEF);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (dout_m[m] !== exp_dout[m] || valid_m[m] !== exp_valid[m]) begin
                errors++;
                $display("FAIL oor_write_%s: dout=%h valid=%b, required %h/%b", mname[m], dout_m[m], valid_m[m], exp_dout[m], exp_valid[m]);
            end
        end
        idle(1);
        drive_access(4'h0, AW'(1023), '0);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (dout_m[m] !== 32'h0 || valid_m[m] !== 1'b1) begin
                errors++;
                $display("FAIL oor_read_%s: dout=%h valid=%b, required 0/1", mname[m], dout_m[m], valid_m[m]);
            end
        end
        idle(1);
        drive_access(4'h0, AW'(8), '0);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (dout_m[m] !== 32'hCAFEF00D) begin
                errors++;
                $display("FAIL oor_no_alias_%s: dout=%h, required cafef00d", mname[m], dout_m[m]);
            end
        end
        idle(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            drive_access(4'($urandom), AW'($urandom_range(0, 47)), $urandom);
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (dout_m[m] !== exp_dout[m] || valid_m[m] !== exp_valid[m]) begin
                    errors++;
                    $display("FAIL random_%s[%0d]: dout=%h valid=%b, required %h/%b", mname[m], i, dout_m[m], valid_m[m], exp_dout[m], exp_valid[m]);
                end
            end
            idle(1 + int'($urandom % 2));
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (valid_m[m] !== 1'b0) begin
                    errors++;
                    $display("FAIL random_idle_%s[%0d]: valid=%b, required 0", mname[m], i, valid_m[m]);
                end
            end
        end
    endtask

    task automatic test_reset_during_clear();
        drive_access(4'hF, AW'(7), 32'hDEADBEEF);
        idle(1);
        drive_access(4'h0, AW'(7), '0);
        idle(1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #2;
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (busy_m[m] !== 1'b0 || dout_m[m] !== '0 || valid_m[m] !== 1'b0) begin
                errors++;
                $display("FAIL abort_clear_%s: busy=%b dout=%h valid=%b, required 0/0/0", mname[m], busy_m[m], dout_m[m], valid_m[m]);
            end
            exp_dout[m] = '0; exp_valid[m] = 1'b0;
        end
        #2;
        rst_n = 1'b1;
        tick();
        test_clear(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_clear(1'b1, 1'b0);
        test_rw_modes();
        test_out_of_range();
        test_random();
        drive_access(4'hF, AW'(3), 32'h13579BDF);
        idle(1);
        test_clear(1'b0, 1'b1);
        test_random();
        test_reset_during_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
